// File: rtl/dvi_tmds_encoder.sv
// -----------------------------------------------------------------------------
// dvi_tmds_encoder
//
// Single-channel DVI TMDS 8b/10b encoder. Each pixel clock one 8-bit colour
// component (de_i=1) or one pair of control bits (de_i=0) is accepted, and one
// DC-balanced 10-bit TMDS character is produced.
//
// Pipeline:
//   stage 1 : transition minimisation -> q_m[8:0], de_s1, ctrl_s1
//   stage 2 : DC balance against running disparity cnt -> tmds_s2
//   optional: extra output register (macro DVI_TMDS_OUT_REG_EN)
// Latency is 2 clocks by default, 3 with DVI_TMDS_OUT_REG_EN defined.
// Encoding results are identical in both builds.
//
// Parameters:
//   RST_CODE   value of tmds_o while in reset (control code for C1C0=00)
// Ports:
//   clk_i      pixel clock
//   rst_i      synchronous, active-high reset
//   data_i     colour component, used when de_i=1
//   ctrl_i     {C1, C0}, used when de_i=0
//   de_i       1 = video data character, 0 = control character
//   tmds_o     encoded character, LSB transmitted first
// -----------------------------------------------------------------------------
module dvi_tmds_encoder #(
  parameter logic [9:0] RST_CODE = 10'b1101010100
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic [1:0] ctrl_i,
  input  logic       de_i,
  output logic [9:0] tmds_o
);

  localparam logic [9:0] CTRL_CODE_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_CODE_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_CODE_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_CODE_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage 1: transition minimisation
  // ---------------------------------------------------------------------------
  logic [3:0] n1_d;
  logic       use_xnor;
  logic [8:0] q_m_d;

  // NOTE: every always_comb output gets a default first so no path can leave it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    logic prev;
    n1_d     = popcount8(data_i);
    use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !data_i[0]);
    q_m_d    = '0;
    prev     = data_i[0];
    q_m_d[0] = prev;
    for (int i = 1; i < 8; i++) begin
      prev     = use_xnor ? ~(prev ^ data_i[i]) : (prev ^ data_i[i]);
      q_m_d[i] = prev;
    end
    q_m_d[8] = ~use_xnor;
  end

  logic [8:0] q_m;
  logic       de_s1;
  logic [1:0] ctrl_s1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_m     <= '0;
      de_s1   <= 1'b0;
      ctrl_s1 <= 2'b00;
    end else begin
      q_m     <= q_m_d;
      de_s1   <= de_i;
      ctrl_s1 <= ctrl_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: DC balance
  // ---------------------------------------------------------------------------
  logic        [3:0] n1q;
  logic signed [4:0] bal;       // n1q - n0q = 2*n1q - 8
  logic signed [4:0] cnt;
  logic signed [4:0] cnt_nxt;
  logic        [9:0] code_nxt;
  logic        [9:0] tmds_s2;

  always_comb begin
    n1q      = popcount8(q_m[7:0]);
    bal      = {n1q, 1'b0} - 5'd8;
    code_nxt = CTRL_CODE_00;
    cnt_nxt  = '0;
    if (!de_s1) begin
      // Control period: disparity restarts from zero for the next data run.
      unique case (ctrl_s1)
        2'b00: code_nxt = CTRL_CODE_00;
        2'b01: code_nxt = CTRL_CODE_01;
        2'b10: code_nxt = CTRL_CODE_10;
        2'b11: code_nxt = CTRL_CODE_11;
        default: code_nxt = CTRL_CODE_00;
      endcase
      cnt_nxt = '0;
    end else if ((cnt == 5'sd0) || (n1q == 4'd4)) begin
      code_nxt = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      cnt_nxt  = q_m[8] ? (cnt + bal) : (cnt - bal);
    end else if ((!cnt[4] && (n1q > 4'd4)) || (cnt[4] && (n1q < 4'd4))) begin
      // cnt is non-zero here, so a clear sign bit means cnt > 0.
      code_nxt = {1'b1, q_m[8], ~q_m[7:0]};
      cnt_nxt  = cnt + (q_m[8] ? 5'sd2 : 5'sd0) - bal;
    end else begin
      code_nxt = {1'b0, q_m[8], q_m[7:0]};
      cnt_nxt  = cnt - (q_m[8] ? 5'sd0 : 5'sd2) + bal;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt     <= '0;
      tmds_s2 <= RST_CODE;
    end else begin
      cnt     <= cnt_nxt;
      tmds_s2 <= code_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional output register for serializer timing closure
  // ---------------------------------------------------------------------------
`ifdef DVI_TMDS_OUT_REG_EN
  logic [9:0] tmds_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) tmds_q <= RST_CODE;
    else       tmds_q <= tmds_s2;
  end

  assign tmds_o = tmds_q;
`else
  assign tmds_o = tmds_s2;
`endif

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// -----------------------------------------------------------------------------
// tb_dvi_tmds_encoder
//
// Self-checking bench for dvi_tmds_encoder: a table of directed vectors with
// hand-computed characters, a mid-line reset sequence, and a random data run
// compared against a behavioural reference model with a running DC-balance
// check on the produced characters.
// -----------------------------------------------------------------------------
module tb_dvi_tmds_encoder;

`ifdef DVI_TMDS_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  localparam logic [9:0] RST_CODE = 10'h354;

  logic       clk_i;
  logic       rst_i;
  logic [7:0] data_i;
  logic [1:0] ctrl_i;
  logic       de_i;
  logic [9:0] tmds_o;

  dvi_tmds_encoder #(.RST_CODE(RST_CODE)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .data_i (data_i),
    .ctrl_i (ctrl_i),
    .de_i   (de_i),
    .tmds_o (tmds_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: tmds_o=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_bal(input int idx, input int disp);
    n_checks++;
    if (disp > 10 || disp < -10) begin
      n_fail++;
      $display("FAIL dc_balance[%0d]: cumulative disparity=%0d allowed=+-10", idx, disp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (integer arithmetic) and expected-output delay line
  // ---------------------------------------------------------------------------
  int         m_cnt = 0;
  logic [9:0] exp_sr [LAT];

  function automatic logic [9:0] model_step(input logic de, input logic [1:0] ctrl,
                                            input logic [7:0] d);
    logic [8:0] q;
    logic [9:0] o;
    int n1, n1q, n0q;
    if (!de) begin
      m_cnt = 0;
      case (ctrl)
        2'b00:   o = 10'b1101010100;
        2'b01:   o = 10'b0010101011;
        2'b10:   o = 10'b0101010100;
        default: o = 10'b1010101011;
      endcase
      return o;
    end
    n1   = $countones(d);
    q    = '0;
    q[0] = d[0];
    if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) q[i] = ~(q[i-1] ^ d[i]);
      q[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i];
      q[8] = 1'b1;
    end
    n1q = $countones(q[7:0]);
    n0q = 8 - n1q;
    if (m_cnt == 0 || n1q == n0q) begin
      if (q[8]) begin
        o = {2'b01, q[7:0]};
        m_cnt += n1q - n0q;
      end else begin
        o = {2'b10, ~q[7:0]};
        m_cnt += n0q - n1q;
      end
    end else if ((m_cnt > 0 && n1q > n0q) || (m_cnt < 0 && n0q > n1q)) begin
      o = {1'b1, q[8], ~q[7:0]};
      m_cnt += (q[8] ? 2 : 0) + n0q - n1q;
    end else begin
      o = {1'b0, q[8], q[7:0]};
      m_cnt += (q[8] ? 0 : -2) + n1q - n0q;
    end
    return o;
  endfunction

  // One clock: the model consumes the inputs present at the edge, then the
  // bench waits 1 time unit so tmds_o is sampled clear of the edge.
  task automatic tick();
    @(posedge clk_i);
    if (rst_i) begin
      m_cnt = 0;
      for (int i = 0; i < LAT; i++) exp_sr[i] = RST_CODE;
    end else begin
      for (int i = LAT - 1; i > 0; i--) exp_sr[i] = exp_sr[i-1];
      exp_sr[0] = model_step(de_i, ctrl_i, data_i);
    end
    #1;
  endtask

  task automatic drive(input logic rst, input logic de, input logic [1:0] ctrl,
                       input logic [7:0] d);
    rst_i  = rst;
    de_i   = de;
    ctrl_i = ctrl;
    data_i = d;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: exp is the character this input produces LAT
  // clocks later.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       rst;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl [64];
  int   n_vec = 0;

  task automatic add(input logic rst, input logic de, input logic [1:0] ctrl,
                     input logic [7:0] d, input logic [9:0] exp);
    tbl[n_vec] = '{rst: rst, de: de, ctrl: ctrl, data: d, exp: exp};
    n_vec++;
  endtask

  initial begin
    int disp;
    drive(1'b1, 1'b0, 2'b00, 8'h00);

    // reset held 3 cycles, release into control 00
    add(1, 0, 2'b00, 8'h00, 10'h354);
    add(1, 0, 2'b00, 8'h00, 10'h354);
    add(1, 0, 2'b00, 8'h00, 10'h354);
    add(0, 0, 2'b00, 8'h00, 10'h354);
    // control codes
    add(0, 0, 2'b01, 8'h00, 10'h0AB);
    add(0, 0, 2'b10, 8'h00, 10'h154);
    add(0, 0, 2'b11, 8'h00, 10'h2AB);
    // disparity walk from cnt=0: -8, +2, -6
    add(0, 1, 2'b00, 8'h00, 10'h100);
    add(0, 1, 2'b00, 8'h00, 10'h3FF);
    add(0, 1, 2'b00, 8'h00, 10'h100);
    add(0, 0, 2'b00, 8'h00, 10'h354);
    // XNOR path from cnt=0 (-8), then invert cases (+2, -6)
    add(0, 1, 2'b00, 8'hFF, 10'h200);
    add(0, 1, 2'b00, 8'h00, 10'h3FF);
    add(0, 1, 2'b00, 8'hFF, 10'h200);
    add(0, 0, 2'b10, 8'h00, 10'h154);
    // balanced q_m with cnt != 0, then non-inverting XNOR (-8,-8,-8,-2,+4,-4)
    add(0, 1, 2'b00, 8'h00, 10'h100);
    add(0, 1, 2'b00, 8'h10, 10'h1F0);
    add(0, 1, 2'b00, 8'h10, 10'h1F0);
    add(0, 1, 2'b00, 8'hFF, 10'h0FF);
    add(0, 1, 2'b00, 8'hFF, 10'h0FF);
    add(0, 1, 2'b00, 8'hFF, 10'h200);
    add(0, 0, 2'b01, 8'h00, 10'h0AB);
    // n1==4 with d[0]=0 takes XNOR (+4, -2)
    add(0, 1, 2'b00, 8'h1E, 10'h25F);
    add(0, 1, 2'b00, 8'h1E, 10'h0A0);
    add(0, 0, 2'b11, 8'h00, 10'h2AB);
    // n1==4 with d[0]=1 takes XOR (-4, +2)
    add(0, 1, 2'b00, 8'h0F, 10'h105);
    add(0, 1, 2'b00, 8'h0F, 10'h3FA);
    add(0, 0, 2'b00, 8'h00, 10'h354);

    for (int i = 0; i < n_vec + LAT - 1; i++) begin
      if (i < n_vec) drive(tbl[i].rst, tbl[i].de, tbl[i].ctrl, tbl[i].data);
      else           drive(1'b0, 1'b0, 2'b00, 8'h00);
      tick();
      if (i < n_vec && tbl[i].rst) check($sformatf("reset_hold%0d", i), tmds_o, RST_CODE);
      if (i >= LAT - 1) check($sformatf("vec%0d", i - (LAT - 1)), tmds_o, tbl[i-(LAT-1)].exp);
    end

    // -------------------------------------------------------------------------
    // Mid-line reset: disparity discarded, control code first, then cnt=0.
    // -------------------------------------------------------------------------
    drive(1'b0, 1'b1, 2'b00, 8'h00);
    for (int i = 0; i < 3; i++) tick();
    drive(1'b1, 1'b1, 2'b00, 8'h00);
    tick();
    check("midreset_assert", tmds_o, 10'h354);
    drive(1'b0, 1'b1, 2'b00, 8'h00);
    for (int i = 1; i < LAT; i++) begin
      tick();
      check($sformatf("midreset_ctrl%0d", i), tmds_o, 10'h354);
    end
    tick();
    check("midreset_first_data", tmds_o, 10'h100);
    tick();
    check("midreset_second_data", tmds_o, 10'h3FF);

    // -------------------------------------------------------------------------
    // Random data run against the model, with cumulative DC-balance bound.
    // -------------------------------------------------------------------------
    drive(1'b0, 1'b0, 2'b00, 8'h00);
    for (int i = 0; i < LAT; i++) begin
      tick();
      check($sformatf("pre_random%0d", i), tmds_o, exp_sr[LAT-1]);
    end
    disp = 0;
    for (int i = 0; i < 10000 + LAT - 1; i++) begin
      if (i < 10000) drive(1'b0, 1'b1, 2'b00, 8'($urandom_range(0, 255)));
      else           drive(1'b0, 1'b0, 2'b00, 8'h00);
      tick();
      check($sformatf("random%0d", i), tmds_o, exp_sr[LAT-1]);
      disp += 2 * $countones(tmds_o) - 10;
      check_bal(i, disp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
